// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the SRAM port arbiter.
// Optional build macro: SRAM_ARB_PERF_EN (see sram_port_arbiter).
package sram_arb_pkg;

    localparam int unsigned SRAM_NUM_REQ    = 4;
    localparam int unsigned SRAM_ADDR_W     = 4;
    localparam int unsigned SRAM_DATA_W     = 256;
    localparam int unsigned SRAM_NUM_WMASKS = SRAM_DATA_W / 8;
    localparam int unsigned ID_W            = $clog2(SRAM_NUM_REQ);

    typedef struct packed {
        logic                       we;
        logic [SRAM_ADDR_W-1:0]     addr;
        logic [SRAM_NUM_WMASKS-1:0] wmask;
        logic [SRAM_DATA_W-1:0]     wdata;
    } sram_req_t;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
        logic            we;
    } inflight_t;

    // Saturating add for the 32-bit performance counters.
    function automatic logic [31:0] sat_add(input logic [31:0] v, input logic [1:0] inc);
        logic [32:0] s;
        s = {1'b0, v} + 33'(inc);
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/sram_arb_rr_pick.sv
// Rotating-priority first-one finder: returns the first unmasked request at or after ptr_i.
module sram_arb_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] mask_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic               vld_o,
    output logic [ID_W-1:0]    id_o
);

    always_comb begin
        int unsigned idx;
        logic [ID_W-1:0] idx_l;
        vld_o = 1'b0;
        id_o  = '0;
        idx   = 0;
        idx_l = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr_i) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_l = idx[ID_W-1:0];
            if (!vld_o && req_i[idx_l] && !mask_i[idx_l]) begin
                vld_o = 1'b1;
                id_o  = idx_l;
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Dual-port SRAM arbiter: grants up to two requesters per cycle and routes read data back.
// Define SRAM_ARB_PERF_EN to add saturating grant / conflict counters.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = SRAM_NUM_REQ,
    parameter int unsigned ADDR_WIDTH = SRAM_ADDR_W,
    parameter int unsigned DATA_WIDTH = SRAM_DATA_W,
    parameter int unsigned NUM_WMASKS = SRAM_NUM_WMASKS
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*NUM_WMASKS-1:0]  req_wmask,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0]  rsp_rdata,
    output logic                           csb0,
    output logic                           web0,
    output logic [ADDR_WIDTH-1:0]          addr0,
    output logic [NUM_WMASKS-1:0]          wmask0,
    output logic [DATA_WIDTH-1:0]          din0,
    input  logic [DATA_WIDTH-1:0]          dout0,
    output logic                           csb1,
    output logic                           web1,
    output logic [ADDR_WIDTH-1:0]          addr1,
    output logic [NUM_WMASKS-1:0]          wmask1,
    output logic [DATA_WIDTH-1:0]          din1,
    input  logic [DATA_WIDTH-1:0]          dout1
`ifdef SRAM_ARB_PERF_EN
    ,
    output logic [31:0]                    perf_grant_cnt,
    output logic [31:0]                    perf_conflict_cnt
`endif
);

    sram_req_t        reqs [NUM_REQ];
    sram_req_t        w0, w1;
    logic [NUM_REQ-1:0] conflict, mask1, oh0, oh1;
    logic             p0_vld, p1_vld, gnt0, gnt1;
    logic [ID_W-1:0]  p0_id, p1_id, last_id;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    inflight_t        inflight_q [2];
    inflight_t        inflight_d [2];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            reqs[i].we    = req_we[i];
            reqs[i].addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            reqs[i].wmask = req_wmask[i*NUM_WMASKS +: NUM_WMASKS];
            reqs[i].wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    sram_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick0 (
        .req_i  (req_valid),
        .mask_i ({NUM_REQ{1'b0}}),
        .ptr_i  (rr_ptr_q),
        .vld_o  (p0_vld),
        .id_o   (p0_id)
    );

    assign w0 = reqs[p0_id];

    // Port 1 may not take the port-0 winner nor anyone colliding with it on a write.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            conflict[i] = (reqs[i].addr == w0.addr) && (reqs[i].we || w0.we);
        end
        mask1 = conflict;
        mask1[p0_id] = 1'b1;
    end

    sram_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick1 (
        .req_i  (req_valid),
        .mask_i (mask1),
        .ptr_i  (rr_ptr_q),
        .vld_o  (p1_vld),
        .id_o   (p1_id)
    );

    assign w1   = reqs[p1_id];
    assign gnt0 = rst_n & p0_vld;
    assign gnt1 = rst_n & p1_vld;

    always_comb begin
        oh0 = '0;
        oh1 = '0;
        oh0[p0_id] = gnt0;
        oh1[p1_id] = gnt1;
        req_ready = oh0 | oh1;
    end

    // Idle ports keep csb low with web high so the macro never replays a stale write.
    always_comb begin
        csb0 = 1'b0; web0 = 1'b1; addr0 = '0; wmask0 = '0; din0 = '0;
        csb1 = 1'b0; web1 = 1'b1; addr1 = '0; wmask1 = '0; din1 = '0;
        if (gnt0) begin
            web0   = ~w0.we;
            addr0  = w0.addr;
            wmask0 = w0.we ? w0.wmask : '0;
            din0   = w0.wdata;
        end
        if (gnt1) begin
            web1   = ~w1.we;
            addr1  = w1.addr;
            wmask1 = w1.we ? w1.wmask : '0;
            din1   = w1.wdata;
        end
    end

    always_comb begin
        last_id  = gnt1 ? p1_id : p0_id;
        rr_ptr_d = rr_ptr_q;
        if (gnt0) begin
            rr_ptr_d = (last_id == ID_W'(NUM_REQ - 1)) ? '0 : last_id + 1'b1;
        end
        inflight_d[0] = '{vld: gnt0, id: p0_id, we: w0.we};
        inflight_d[1] = '{vld: gnt1, id: p1_id, we: w1.we};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q      <= '0;
            inflight_q[0] <= '0;
            inflight_q[1] <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            inflight_q[0] <= inflight_d[0];
            inflight_q[1] <= inflight_d[1];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = 1'b0;
            rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = dout0;
            if (inflight_q[1].vld && inflight_q[1].id == ID_W'(i)) begin
                rsp_valid[i] = 1'b1;
                rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = dout1;
            end
            if (inflight_q[0].vld && inflight_q[0].id == ID_W'(i)) begin
                rsp_valid[i] = 1'b1;
                rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = dout0;
            end
        end
    end

`ifdef SRAM_ARB_PERF_EN
    logic [31:0] grant_cnt_q, grant_cnt_d, conflict_cnt_q, conflict_cnt_d;
    logic        conflict_skip;

    always_comb begin
        conflict_skip  = gnt0 && |(req_valid & conflict & ~oh0);
        grant_cnt_d    = sat_add(grant_cnt_q, {1'b0, gnt0} + {1'b0, gnt1});
        conflict_cnt_d = sat_add(conflict_cnt_q, {1'b0, conflict_skip});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            grant_cnt_q    <= grant_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign perf_grant_cnt    = grant_cnt_q;
    assign perf_conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter with a behavioural dual-port SRAM and reference model.
module tb_sram_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 256;
    localparam int MW = 32;

    typedef logic [1:0] id_t;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  we;
        logic [15:0] addrs;
        logic [3:0]  exp_ready;
    } vec_t;

    logic            clk, rst_n;
    logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*MW-1:0] req_wmask;
    logic [N*DW-1:0] req_wdata, rsp_rdata;
    logic            csb0, web0, csb1, web1;
    logic [AW-1:0]   addr0, addr1;
    logic [MW-1:0]   wmask0, wmask1;
    logic [DW-1:0]   din0, din1, dout0, dout1;

    sram_port_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wmask (req_wmask),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .csb0      (csb0),
        .web0      (web0),
        .addr0     (addr0),
        .wmask0    (wmask0),
        .din0      (din0),
        .dout0     (dout0),
        .csb1      (csb1),
        .web1      (web1),
        .addr1     (addr1),
        .wmask1    (wmask1),
        .din1      (din1),
        .dout1     (dout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM macro: registered read, byte-masked write.
    logic [DW-1:0] sram_mem [16];
    always @(posedge clk) begin
        if (!csb0) begin
            if (!web0) begin
                for (int b = 0; b < MW; b++) if (wmask0[b]) sram_mem[addr0][b*8 +: 8] <= din0[b*8 +: 8];
            end else begin
                dout0 <= sram_mem[addr0];
            end
        end
        if (!csb1) begin
            if (!web1) begin
                for (int b = 0; b < MW; b++) if (wmask1[b]) sram_mem[addr1][b*8 +: 8] <= din1[b*8 +: 8];
            end else begin
                dout1 <= sram_mem[addr1];
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [N-1:0]  s_valid, s_we;
    logic [AW-1:0] s_addr  [N];
    logic [MW-1:0] s_wmask [N];
    logic [DW-1:0] s_wdata [N];

    logic [DW-1:0] ref_mem   [16];
    logic [MW-1:0] ref_known [16];
    id_t           ref_ptr;

    logic          exp_vld   [N];
    logic          exp_we    [N];
    logic [DW-1:0] exp_data  [N];
    logic [MW-1:0] exp_known [N];
    logic          obs_vld   [N];
    logic [DW-1:0] obs_data  [N];
    int            rsp_cnt   [N];

    vec_t vecs [10];

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] expand(input logic [MW-1:0] m);
        logic [DW-1:0] r;
        for (int b = 0; b < MW; b++) r[b*8 +: 8] = {8{m[b]}};
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int w = 0; w < DW / 32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic clr();
        s_valid = '0;
        s_we    = '0;
        for (int i = 0; i < N; i++) begin
            s_addr[i]  = '0;
            s_wmask[i] = '0;
            s_wdata[i] = '0;
        end
    endtask

    task automatic set_req(input id_t id, input logic we, input logic [AW-1:0] a,
                           input logic [MW-1:0] m, input logic [DW-1:0] d);
        s_valid[id] = 1'b1;
        s_we[id]    = we;
        s_addr[id]  = a;
        s_wmask[id] = m;
        s_wdata[id] = d;
    endtask

    task automatic drive();
        req_valid = s_valid;
        req_we    = s_we;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = s_addr[i];
            req_wmask[i*MW +: MW] = s_wmask[i];
            req_wdata[i*DW +: DW] = s_wdata[i];
        end
    endtask

    task automatic check_rsp();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rsp_valid[%0d]", i), DW'(rsp_valid[i]), DW'(exp_vld[i]));
            obs_vld[i]  = rsp_valid[i];
            obs_data[i] = rsp_rdata[i*DW +: DW];
            if (rsp_valid[i]) rsp_cnt[i]++;
            if (exp_vld[i] && !exp_we[i] && exp_known[i] != '0)
                chk($sformatf("rsp_rdata[%0d]", i), obs_data[i] & expand(exp_known[i]),
                    exp_data[i] & expand(exp_known[i]));
            exp_vld[i] = 1'b0;
        end
    endtask

    task automatic chk_port(input string nm, input logic g, input id_t p, input logic csb,
                            input logic web, input logic [AW-1:0] a, input logic [MW-1:0] m,
                            input logic [DW-1:0] din);
        logic [AW+MW+1:0] exp;
        exp = {1'b0, 1'b1, {AW{1'b0}}, {MW{1'b0}}};
        if (g) exp = {1'b0, ~s_we[p], s_addr[p], s_we[p] ? s_wmask[p] : {MW{1'b0}}};
        chk(nm, DW'({csb, web, a, m}), DW'(exp));
        if (g && s_we[p]) chk({nm, "_din"}, din, s_wdata[p]);
    endtask

    // Reference: scan from the pointer, first valid takes port 0, next non-conflicting takes port 1.
    task automatic predict();
        logic g0, g1;
        id_t  p0, p1, id;
        logic [N-1:0] er;
        g0 = 1'b0; g1 = 1'b0; p0 = '0; p1 = '0;
        for (int k = 0; k < N; k++) begin
            id = ref_ptr + id_t'(k);
            if (s_valid[id]) begin
                if (!g0) begin
                    g0 = 1'b1; p0 = id;
                end else if (!g1 && !(s_addr[id] == s_addr[p0] && (s_we[id] || s_we[p0]))) begin
                    g1 = 1'b1; p1 = id;
                end
            end
        end
        er = '0;
        if (g0) er[p0] = 1'b1;
        if (g1) er[p1] = 1'b1;
        chk("req_ready", DW'(req_ready), DW'(er));
        chk_port("port0", g0, p0, csb0, web0, addr0, wmask0, din0);
        chk_port("port1", g1, p1, csb1, web1, addr1, wmask1, din1);
        if (g0) begin
            exp_vld[p0] = 1'b1; exp_we[p0] = s_we[p0];
            exp_data[p0] = ref_mem[s_addr[p0]]; exp_known[p0] = ref_known[s_addr[p0]];
        end
        if (g1) begin
            exp_vld[p1] = 1'b1; exp_we[p1] = s_we[p1];
            exp_data[p1] = ref_mem[s_addr[p1]]; exp_known[p1] = ref_known[s_addr[p1]];
        end
        for (int j = 0; j < 2; j++) begin
            id = (j == 0) ? p0 : p1;
            if (((j == 0) ? g0 : g1) && s_we[id]) begin
                for (int b = 0; b < MW; b++)
                    if (s_wmask[id][b]) ref_mem[s_addr[id]][b*8 +: 8] = s_wdata[id][b*8 +: 8];
                ref_known[s_addr[id]] = ref_known[s_addr[id]] | s_wmask[id];
            end
        end
        if (g1) ref_ptr = p1 + 2'd1;
        else if (g0) ref_ptr = p0 + 2'd1;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_rsp();
        drive();
        #1;
        if (rst_n) begin
            predict();
        end else begin
            chk("reset_ready", DW'(req_ready), '0);
            chk("reset_port0", DW'({csb0, web0, addr0, wmask0}), DW'({2'b01, {(AW+MW){1'b0}}}));
            chk("reset_port1", DW'({csb1, web1, addr1, wmask1}), DW'({2'b01, {(AW+MW){1'b0}}}));
        end
    endtask

    task automatic enter_reset();
        rst_n   = 1'b0;
        ref_ptr = '0;
        for (int i = 0; i < N; i++) exp_vld[i] = 1'b0;
    endtask

    task automatic do_reset();
        enter_reset();
        clr();
        for (int i = 0; i < N; i++) set_req(id_t'(i), 1'b0, AW'(i), '1, '0);
        cycle();
        cycle();
        clr();
        drive();
        rst_n = 1'b1;
    endtask

    logic [DW-1:0] d_a, d_b, d_exp;

    initial begin
        vecs[0] = '{valid: 4'b0000, we: 4'b0000, addrs: 16'h0000, exp_ready: 4'b0000};
        vecs[1] = '{valid: 4'b1111, we: 4'b0000, addrs: 16'h3210, exp_ready: 4'b0011};
        vecs[2] = '{valid: 4'b1111, we: 4'b0000, addrs: 16'h3210, exp_ready: 4'b1100};
        vecs[3] = '{valid: 4'b0101, we: 4'b0101, addrs: 16'h0303, exp_ready: 4'b0001};
        vecs[4] = '{valid: 4'b0100, we: 4'b0100, addrs: 16'h0300, exp_ready: 4'b0100};
        vecs[5] = '{valid: 4'b1001, we: 4'b0000, addrs: 16'h7007, exp_ready: 4'b1001};
        vecs[6] = '{valid: 4'b0011, we: 4'b0001, addrs: 16'h0022, exp_ready: 4'b0010};
        vecs[7] = '{valid: 4'b1110, we: 4'b0010, addrs: 16'h5440, exp_ready: 4'b1100};
        vecs[8] = '{valid: 4'b0010, we: 4'b0000, addrs: 16'h0010, exp_ready: 4'b0010};
        vecs[9] = '{valid: 4'b1111, we: 4'b1111, addrs: 16'h9999, exp_ready: 4'b0100};

        for (int a = 0; a < 16; a++) begin
            ref_mem[a]   = '0;
            ref_known[a] = '0;
        end
        for (int i = 0; i < N; i++) begin
            exp_vld[i] = 1'b0; exp_we[i] = 1'b0; exp_data[i] = '0; exp_known[i] = '0;
            rsp_cnt[i] = 0;
        end
        clr();
        drive();
        do_reset();

        // Idle after reset
        clr();
        repeat (3) cycle();

        // Write then read-after-write from another requester
        d_a = {32{8'hA5}};
        clr(); set_req(2'd0, 1'b1, 4'd5, '1, d_a); cycle();
        chk("raw_wr_ready", DW'(req_ready), DW'(4'b0001));
        clr(); set_req(2'd1, 1'b0, 4'd5, '0, '0); cycle();
        chk("raw_rd_ready", DW'(req_ready), DW'(4'b0010));
        clr(); cycle();
        chk("raw_rsp_vld", DW'(obs_vld[1]), DW'(1'b1));
        chk("raw_rsp_data", obs_data[1], d_a);

        // Same-address write/write: only requester 0 this cycle, requester 2 next
        d_a = {32{8'h0D}};
        d_b = {32{8'h2D}};
        clr(); set_req(2'd3, 1'b0, 4'd0, '0, '0); cycle();
        clr(); set_req(2'd0, 1'b1, 4'd3, '1, d_a); set_req(2'd2, 1'b1, 4'd3, '1, d_b); cycle();
        chk("waw_ready0", DW'(req_ready), DW'(4'b0001));
        clr(); set_req(2'd2, 1'b1, 4'd3, '1, d_b); cycle();
        chk("waw_ready2", DW'(req_ready), DW'(4'b0100));
        clr(); set_req(2'd1, 1'b0, 4'd3, '0, '0); cycle();
        clr(); cycle();
        chk("waw_final", obs_data[1], d_b);

        // Four continuous readers of distinct words
        clr(); set_req(2'd3, 1'b0, 4'd0, '0, '0); cycle();
        for (int k = 0; k < 4; k++) begin
            clr();
            for (int i = 0; i < N; i++) set_req(id_t'(i), 1'b0, AW'(8 + i), '0, '0);
            cycle();
            chk($sformatf("rr_pair%0d", k), DW'(req_ready), DW'((k % 2 == 0) ? 4'b0011 : 4'b1100));
            if (k == 0) for (int i = 0; i < N; i++) rsp_cnt[i] = 0;
        end
        clr(); cycle();
        for (int i = 0; i < N; i++) chk($sformatf("rr_rsp_cnt%0d", i), DW'(rsp_cnt[i]), DW'(2));

        // Byte-masked write into a word of all 0xFF
        clr(); set_req(2'd1, 1'b1, 4'd6, '1, '1); cycle();
        clr(); set_req(2'd2, 1'b1, 4'd6, 32'h0000_0001, {32{8'h11}}); cycle();
        clr(); set_req(2'd3, 1'b0, 4'd6, '0, '0); cycle();
        clr(); cycle();
        d_exp = {{31{8'hFF}}, 8'h11};
        chk("bytemask_data", obs_data[3], d_exp);

        // Reset with two reads in flight, then write/read addr 0
        clr(); set_req(2'd0, 1'b0, 4'd5, '0, '0); set_req(2'd1, 1'b0, 4'd3, '0, '0); cycle();
        #1;
        enter_reset();
        clr();
        for (int i = 0; i < N; i++) set_req(id_t'(i), 1'b0, AW'(i), '0, '0);
        cycle();
        cycle();
        clr(); drive(); rst_n = 1'b1;
        d_a = rand_data();
        clr(); set_req(2'd0, 1'b1, 4'd0, '1, d_a); cycle();
        clr(); set_req(2'd1, 1'b0, 4'd0, '0, '0); cycle();
        clr(); cycle();
        chk("post_reset_rd", obs_data[1], d_a);

        // Table vectors from a fresh pointer
        do_reset();
        for (int k = 0; k < 10; k++) begin
            clr();
            for (int i = 0; i < N; i++)
                if (vecs[k].valid[i])
                    set_req(id_t'(i), vecs[k].we[i], vecs[k].addrs[4*i +: 4], '1, rand_data());
            cycle();
            chk($sformatf("vec%0d_ready", k), DW'(req_ready), DW'(vecs[k].exp_ready));
        end

        // Randomized traffic on a small address window to provoke conflicts
        for (int c = 0; c < 3000; c++) begin
            clr();
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 99) < 70)
                    set_req(id_t'(i), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)),
                            ($urandom_range(0, 3) == 0) ? '1 : MW'($urandom), rand_data());
            cycle();
        end
        clr();
        cycle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
